sprite_line_scheduler: RTL
==========================

# sprite_line_scheduler

Renders one video line of sprites ahead of the beam into a ping-pong line buffer. At the start of each horizontal blank it clears the back bank, scans the 20-entry sprite table for sprites that intersect the next line, fetches each visible sprite's pixel row from the sprite ROM, and writes the opaque pixels. It sits between the sprite table and the display-side line buffer read path.

## Interface
- NUM_SPRITES, 20, number of sprite table entries
- MAX_PER_LINE, 8, maximum sprites drawn per line
- BG_COLOR, 24'h000000, colour written during the clear phase
- TRANSPARENT, 24'hFF00FF, ROM colour that is never written
- clk  in  1  system clock, 50 MHz; one VGA pixel lasts 2 clk cycles
- reset  in  1  synchronous, active-high
- gl_array  in  24 x NUM_SPRITES  sprite entries; bits [23:19] type (0 = disabled), [18:9] x, [8:0] y
- VGA_HCOUNT  in  10  current pixel column, 0..799
- VGA_VCOUNT  in  10  current line, 0..524
- rom_addr  out  15  {type[4:0], row[4:0], col[4:0]}
- rom_data  in  24  sprite ROM pixel; valid exactly 1 cycle after rom_addr
- lb_we  out  1  line buffer write strobe
- lb_waddr  out  10  line buffer write column
- lb_wdata  out  24  line buffer write pixel
- lb_sel  out  1  bank being written; the display reads ~lb_sel
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  one-cycle pulse: a new line started before rendering finished
- sprite_drop  out  1  one-cycle pulse: more than MAX_PER_LINE hits on a line

## Operation
- line_start is a one-cycle event on the first clk where VGA_HCOUNT == 640. The previous-cycle value is registered for edge detection.
- Target line t = VGA_VCOUNT + 1; VGA_VCOUNT == 524 gives t = 0.
  - If t < 480, the line is accepted: lb_sel toggles, a hit counter and scan index are cleared, and the FSM enters CLEAR.
  - If t >= 480, nothing happens.
- **CLEAR:** writes BG_COLOR to columns 0..639, one per cycle, then goes to SCAN at index 0.
- **SCAN:** examines one entry per cycle at index i.
  - Hit condition: type != 0 and (t − y) in 0..31, using 10-bit unsigned subtraction with y zero-extended.
  - On a hit with hits < MAX_PER_LINE: latch row = (t − y)[4:0], x, and type, increment hits, go to DRAW.
  - On a hit with hits == MAX_PER_LINE: pulse sprite_drop on the first such hit only, then continue scanning.
  - After i = NUM_SPRITES − 1 is examined and handled, go to IDLE.
- **DRAW:** 33 cycles.
  - Cycle k (0..31) drives rom_addr = {type, row, k}.
  - Cycle k+1 writes lb_waddr = x + k, lb_wdata = rom_data.
  - The write is suppressed if rom_data == TRANSPARENT or x + k > 639, computed with 11-bit arithmetic (no wrap).
  - After the drain cycle, return to SCAN at i + 1.
- Priority: later writes overwrite earlier ones, so a higher table index is drawn on top.
- gl_array is sampled live; the table is not snapshotted.
- line_start while busy:
  - overrun pulses in the same cycle as line_start.
  - The current work is abandoned: any DRAW in flight is dropped, including a pending write.
  - The new line is then handled normally; if accepted, lb_sel toggles and the FSM enters CLEAR.

## Timing
- Reset values: lb_we, lb_waddr, lb_wdata, rom_addr, lb_sel, busy, overrun, sprite_drop all 0; FSM in IDLE.
- Reset mid-operation returns the block to the reset state on the next edge; no write is issued after reset is sampled.
- First CLEAR write occurs 1 cycle after line_start.
- Worst-case render length is 640 + 20 + 8×33 = 924 cycles, within the 1600-cycle line period.
- lb_we is high for exactly one cycle per written pixel; lb_waddr and lb_wdata are valid in that cycle.
- rom_addr changes only in DRAW; it holds its last value elsewhere.
- busy rises in the cycle after line_start and falls in the cycle IDLE is entered.

## Test plan
- **Single sprite:** entry 0 = {type 3, x 100, y 50}, VGA_VCOUNT 49, HCOUNT reaches 640.
  - Expect 640 BG writes to addresses 0..639.
  - Then rom_addr {3, 0, 0..31} and 32 writes to addresses 100..131; lb_sel toggles 0→1.
- **Clip and transparency:** x = 620, ROM col 5 = 24'hFF00FF.
  - Expect writes only at 620..639, excluding 625.
- **Overflow:** 10 enabled sprites all covering t.
  - Expect indices 0..7 drawn, indices 8 and 9 absent, and sprite_drop high for exactly one cycle.
- **Wrap and vertical blank:** VGA_VCOUNT 524 renders t = 0.
  - VGA_VCOUNT 479 (t = 480) gives no writes, busy stays 0, and lb_sel is unchanged.
- **Overrun:** force line_start during DRAW.
  - Expect an overrun pulse in that cycle, lb_sel toggles, and the next write is BG to address 0.
- **Reset in DRAW:** assert reset for 1 cycle.
  - Expect all outputs 0 on the next cycle and no further lb_we until the next line_start.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Renders the next video line's sprites into the back bank of a ping-pong line buffer.
// Each horizontal blank: clear the bank, scan the sprite table, and draw up to MAX_PER_LINE sprite rows.
module sprite_line_scheduler #(
    parameter int          NUM_SPRITES  = 20,
    parameter int          MAX_PER_LINE = 8,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter logic [23:0] TRANSPARENT  = 24'hFF00FF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SPRITES-1:0][23:0] gl_array,
    input  logic [9:0]                   VGA_HCOUNT,
    input  logic [9:0]                   VGA_VCOUNT,
    output logic [14:0]                  rom_addr,
    input  logic [23:0]                  rom_data,
    output logic                         lb_we,
    output logic [9:0]                   lb_waddr,
    output logic [23:0]                  lb_wdata,
    output logic                         lb_sel,
    output logic                         busy,
    output logic                         overrun,
    output logic                         sprite_drop
);

    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int HW = $clog2(MAX_PER_LINE + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
    localparam logic [HW-1:0] MAX_HITS = HW'(MAX_PER_LINE);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAW} state_t;

    state_t         r_state;
    state_t         w_next;

    logic [9:0]     r_hcount_prev;
    logic [9:0]     r_t;
    logic           r_lb_sel;
    logic [9:0]     r_clr_cnt;
    logic [IW-1:0]  r_idx;
    logic [HW-1:0]  r_hits;
    logic           r_dropped;
    logic [5:0]     r_k;
    logic [4:0]     r_row;
    logic [9:0]     r_x;
    logic [4:0]     r_type;
    logic [14:0]    r_rom_addr;

    logic           w_line_start;
    logic [9:0]     w_target;
    logic           w_accept;
    logic [23:0]    w_entry;
    logic [4:0]     w_type;
    logic [9:0]     w_diff;
    logic           w_hit;
    logic           w_room;
    logic           w_last;
    logic [4:0]     w_col;
    logic [10:0]    w_px;
    logic           w_draw_we;

    assign w_line_start = (VGA_HCOUNT == 10'd640) && (r_hcount_prev != 10'd640);
    assign w_target     = (VGA_VCOUNT == 10'd524) ? 10'd0 : VGA_VCOUNT + 10'd1;
    assign w_accept     = (w_target < 10'd480);

    // Table is read live, one entry per SCAN cycle.
    assign w_entry = gl_array[r_idx];
    assign w_type  = w_entry[23:19];
    assign w_diff  = r_t - {1'b0, w_entry[8:0]};
    assign w_hit   = (w_type != 5'd0) && (w_diff[9:5] == 5'd0);
    assign w_room  = (r_hits < MAX_HITS);
    assign w_last  = (r_idx == LAST_IDX);

    // ROM data lags the address by one cycle, so the pixel written at r_k belongs to column r_k-1.
    assign w_col     = r_k[4:0] - 5'd1;
    assign w_px      = {1'b0, r_x} + {6'd0, w_col};
    assign w_draw_we = (r_state == S_DRAW) && (r_k != 6'd0) &&
                       (rom_data != TRANSPARENT) && (w_px <= 11'd639);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a new line always preempts whatever is in flight.
    always_comb begin
        w_next = r_state;
        if (w_line_start) begin
            w_next = w_accept ? S_CLEAR : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_CLEAR: if (r_clr_cnt == 10'd639) w_next = S_SCAN;
                S_SCAN: begin
                    if (w_hit && w_room) w_next = S_DRAW;
                    else if (w_last)     w_next = S_IDLE;
                end
                S_DRAW: if (r_k == 6'd32) w_next = w_last ? S_IDLE : S_SCAN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcount_prev <= 10'd0;
            r_t           <= 10'd0;
            r_lb_sel      <= 1'b0;
            r_clr_cnt     <= 10'd0;
            r_idx         <= '0;
            r_hits        <= '0;
            r_dropped     <= 1'b0;
            r_k           <= 6'd0;
            r_row         <= 5'd0;
            r_x           <= 10'd0;
            r_type        <= 5'd0;
            r_rom_addr    <= 15'd0;
        end else begin
            r_hcount_prev <= VGA_HCOUNT;
            if (w_line_start) begin
                if (w_accept) begin
                    r_t       <= w_target;
                    r_lb_sel  <= ~r_lb_sel;
                    r_clr_cnt <= 10'd0;
                    r_idx     <= '0;
                    r_hits    <= '0;
                    r_dropped <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_CLEAR: r_clr_cnt <= r_clr_cnt + 10'd1;
                    S_SCAN: begin
                        if (w_hit && w_room) begin
                            r_row      <= w_diff[4:0];
                            r_x        <= w_entry[18:9];
                            r_type     <= w_type;
                            r_hits     <= r_hits + HW'(1);
                            r_k        <= 6'd0;
                            r_rom_addr <= {w_type, w_diff[4:0], 5'd0};
                        end else begin
                            if (w_hit) r_dropped <= 1'b1;
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                    S_DRAW: begin
                        r_k <= r_k + 6'd1;
                        if (r_k < 6'd31) r_rom_addr <= {r_type, r_row, r_k[4:0] + 5'd1};
                        if (r_k == 6'd32) r_idx <= r_idx + IW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs; writes are squashed while reset is asserted and on the cycle a new line preempts.
    always_comb begin
        busy        = (r_state != S_IDLE);
        overrun     = !reset && w_line_start && (r_state != S_IDLE);
        sprite_drop = !reset && !w_line_start && (r_state == S_SCAN) &&
                      w_hit && !w_room && !r_dropped;
        lb_we       = 1'b0;
        lb_waddr    = 10'd0;
        lb_wdata    = 24'd0;
        if (!reset && !w_line_start) begin
            if (r_state == S_CLEAR) begin
                lb_we    = 1'b1;
                lb_waddr = r_clr_cnt;
                lb_wdata = BG_COLOR;
            end else if (w_draw_we) begin
                lb_we    = 1'b1;
                lb_waddr = w_px[9:0];
                lb_wdata = rom_data;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign lb_sel   = r_lb_sel;

endmodule
